// File: rtl/xor_cipher_cfg_ctrl.sv
// Configure-then-run sequencer for the dual XOR cipher: serially loads the LFSR
// config chain (capturing its old image), then enables the cipher for a bounded run.
module xor_cipher_cfg_ctrl #(
  parameter int unsigned M     = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   run_len,
  input  logic               mux_ext_a,
  input  logic               mux_en_d,
  input  logic [M-1:0]       tx_lfsr_taps,
  input  logic [M-1:0]       tx_lfsr_state,
  input  logic [M-1:0]       rx_lfsr_taps,
  input  logic [M-1:0]       rx_lfsr_state,
  output logic               cfg_en,
  output logic               cfg_o,
  input  logic               cfg_i,
  output logic               en,
  output logic               busy,
  output logic               done,
  output logic [4*M+1:0]     readback,
  output logic [CNT_W-1:0]   cycles_run
);

  localparam int unsigned L    = 4 * M + 2;
  localparam int unsigned BC_W = $clog2(L);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(L - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_SETTLE, S_RUN, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic [L-1:0]     sr_q, sr_d;
  logic [L-1:0]     readback_q, readback_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic [CNT_W-1:0] cycles_run_q, cycles_run_d;
  logic             cfg_en_q, cfg_en_d;
  logic             cfg_o_q, cfg_o_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             shift_last;
  logic             run_last;
  logic [L-1:0]     cfg_vec;

  assign cfg_vec    = {mux_ext_a, mux_en_d, tx_lfsr_taps, tx_lfsr_state,
                       rx_lfsr_taps, rx_lfsr_state};
  assign shift_last = (bit_cnt_q == LAST_BIT);
  assign run_last   = stop ||
                      ((run_len_q != '0) && (cycles_run_q == run_len_q - CNT_W'(1)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; the start request is registered once, so LOAD begins one edge later
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_q) state_d = S_LOAD;
      S_LOAD:   state_d = S_SHIFT;
      S_SHIFT:  if (shift_last) state_d = S_SETTLE;
      S_SETTLE: state_d = S_RUN;
      S_RUN:    if (run_last) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values; outputs decode the next state so they are registered
  always_comb begin
    req_d        = (state_q == S_IDLE) && !req_q && start;
    sr_d         = sr_q;
    readback_d   = readback_q;
    bit_cnt_d    = bit_cnt_q;
    run_len_d    = run_len_q;
    cycles_run_d = cycles_run_q;
    case (state_q)
      S_LOAD: begin
        sr_d         = cfg_vec;
        run_len_d    = run_len;
        cycles_run_d = '0;
        bit_cnt_d    = '0;
      end
      S_SHIFT: begin
        sr_d      = {cfg_i, sr_q[L-1:1]};
        bit_cnt_d = bit_cnt_q + BC_W'(1);
        if (shift_last) readback_d = sr_d;
      end
      S_RUN: begin
        if (cycles_run_q != CNT_MAX) cycles_run_d = cycles_run_q + CNT_W'(1);
      end
      default: ;
    endcase
    cfg_en_d = (state_d == S_SHIFT);
    cfg_o_d  = cfg_en_d & sr_d[0];
    en_d     = (state_d == S_RUN);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q        <= 1'b0;
      sr_q         <= '0;
      readback_q   <= '0;
      bit_cnt_q    <= '0;
      run_len_q    <= '0;
      cycles_run_q <= '0;
      cfg_en_q     <= 1'b0;
      cfg_o_q      <= 1'b0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      req_q        <= req_d;
      sr_q         <= sr_d;
      readback_q   <= readback_d;
      bit_cnt_q    <= bit_cnt_d;
      run_len_q    <= run_len_d;
      cycles_run_q <= cycles_run_d;
      cfg_en_q     <= cfg_en_d;
      cfg_o_q      <= cfg_o_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign cfg_en     = cfg_en_q;
  assign cfg_o      = cfg_o_q;
  assign en         = en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign readback   = readback_q;
  assign cycles_run = cycles_run_q;

endmodule

// File: tb/tb_xor_cipher_cfg_ctrl.sv
// Directed bench for xor_cipher_cfg_ctrl: chain model, serial-bit scoreboard,
// cycle-accurate phase checks, early stop, ignored requests, reset and saturation.
module tb_xor_cipher_cfg_ctrl;

  localparam int unsigned M = 32;
  localparam int unsigned L = 4 * M + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start, stop;
  logic [15:0]   run_len;
  logic          mux_ext_a, mux_en_d;
  logic [M-1:0]  tx_lfsr_taps, tx_lfsr_state, rx_lfsr_taps, rx_lfsr_state;
  logic          cfg_en, cfg_o, cfg_i, en, busy, done;
  logic [L-1:0]  readback;
  logic [15:0]   cycles_run;

  logic          start_s, stop_s, cfg_i_s;
  logic [3:0]    run_len_s;
  logic          cfg_en_s, cfg_o_s, en_s, busy_s, done_s;
  logic [L-1:0]  readback_s;
  logic [3:0]    cycles_run_s;

  xor_cipher_cfg_ctrl #(.M(M), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .run_len(run_len),
    .mux_ext_a(mux_ext_a), .mux_en_d(mux_en_d),
    .tx_lfsr_taps(tx_lfsr_taps), .tx_lfsr_state(tx_lfsr_state),
    .rx_lfsr_taps(rx_lfsr_taps), .rx_lfsr_state(rx_lfsr_state),
    .cfg_en(cfg_en), .cfg_o(cfg_o), .cfg_i(cfg_i), .en(en), .busy(busy),
    .done(done), .readback(readback), .cycles_run(cycles_run)
  );

  xor_cipher_cfg_ctrl #(.M(M), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .stop(stop_s), .run_len(run_len_s),
    .mux_ext_a(mux_ext_a), .mux_en_d(mux_en_d),
    .tx_lfsr_taps(tx_lfsr_taps), .tx_lfsr_state(tx_lfsr_state),
    .rx_lfsr_taps(rx_lfsr_taps), .rx_lfsr_state(rx_lfsr_state),
    .cfg_en(cfg_en_s), .cfg_o(cfg_o_s), .cfg_i(cfg_i_s), .en(en_s), .busy(busy_s),
    .done(done_s), .readback(readback_s), .cycles_run(cycles_run_s)
  );

  // Model of the external configuration chain; its tail feeds cfg_i
  logic [L-1:0] chain;
  logic [L-1:0] chain_init;
  logic         chain_load;
  always @(posedge clk) begin
    if (chain_load)  chain <= chain_init;
    else if (cfg_en) chain <= {cfg_o, chain[L-1:1]};
  end
  assign cfg_i = chain[0];

  int n_chk  = 0;
  int n_fail = 0;
  bit exp_q[$];

  task automatic chk(input string tag, input logic [L-1:0] obs, input logic [L-1:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [L-1:0] rand_vec();
    logic [L-1:0] v;
    for (int i = 0; i < L; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // One full configure-then-run sequence on the main DUT
  task automatic do_seq(input logic [L-1:0] v, input logic [15:0] rl, input int stop_cycle,
                        input bit pokes, input bit stop_with_start,
                        input logic [L-1:0] exp_rb, input int exp_en);
    int n_cfg = 0, n_en = 0, n_done = 0, n_busy = 0, post = 0;
    int first_cfg = -1, first_en = -1, done_cyc = -1;
    int budget = int'(L) + int'(rl) + stop_cycle + 20;
    {mux_ext_a, mux_en_d, tx_lfsr_taps, tx_lfsr_state, rx_lfsr_taps, rx_lfsr_state} = v;
    run_len = rl;
    exp_q.delete();
    for (int i = 0; i < L; i++) exp_q.push_back(v[i]);
    @(negedge clk);
    start = 1'b1;
    stop  = stop_with_start;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("busy_cycle0", L'(busy), L'(0));
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      if (busy) n_busy++;
      if (cfg_en) begin
        n_cfg++;
        if (first_cfg < 0) first_cfg = cyc;
        if (exp_q.size() > 0) chk("cfg_o_bit", L'(cfg_o), L'(exp_q.pop_front()));
        else chk("cfg_en_extra", L'(cfg_en), L'(0));
        if (pokes && n_cfg == 10) start = 1'b1;
        if (pokes && n_cfg == 20) stop = 1'b1;
      end
      if (en) begin
        n_en++;
        if (first_en < 0) first_en = cyc;
        if (pokes && n_en == 5) start = 1'b1;
        if (stop_cycle > 0 && n_en == stop_cycle) stop = 1'b1;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (n_done > 0) post++;
      if (post > 3) break;
    end
    chk("cfg_en_count", L'(n_cfg), L'(L));
    chk("cfg_en_first", L'(first_cfg), L'(2));
    chk("cfg_bits_left", L'(exp_q.size()), L'(0));
    chk("en_count", L'(n_en), L'(exp_en));
    chk("en_first", L'(first_en), L'(L + 3));
    chk("done_count", L'(n_done), L'(1));
    chk("done_cycle", L'(done_cyc), L'(int'(L) + 3 + exp_en));
    chk("busy_count", L'(n_busy), L'(int'(L) + 3 + exp_en));
    chk("busy_after", L'(busy), L'(0));
    chk("readback", readback, exp_rb);
    chk("cycles_run", L'(cycles_run), L'(exp_en));
  endtask

  logic [L-1:0] v1, v2, v3, v4, v5;
  int n;

  initial begin
    rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; run_len = '0;
    start_s = 1'b0; stop_s = 1'b0; run_len_s = '0; cfg_i_s = 1'b0;
    {mux_ext_a, mux_en_d, tx_lfsr_taps, tx_lfsr_state, rx_lfsr_taps, rx_lfsr_state} = '0;
    chain_load = 1'b1;
    chain_init = '1;
    repeat (3) @(negedge clk);
    chk("rst_cfg_en", L'(cfg_en), L'(0));
    chk("rst_busy", L'(busy), L'(0));
    chk("rst_readback", readback, L'(0));
    chk("rst_cycles_run", L'(cycles_run), L'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chain_load = 1'b0;

    // Reference config with ignored start/stop pokes during SHIFT and RUN
    v1 = {1'b1, 1'b0, {4{32'hA5A5_0F0F}}};
    do_seq(v1, 16'd900, 0, 1'b1, 1'b0, '1, 900);

    // Round trip; stop asserted together with start in IDLE is ignored
    v2 = rand_vec();
    do_seq(v2, 16'd7, 0, 1'b0, 1'b1, v1, 7);

    // Early stop in the 51st RUN cycle
    v3 = rand_vec();
    do_seq(v3, 16'd0, 51, 1'b0, 1'b0, v2, 51);

    // Asynchronous reset at shift bit 60
    v4 = rand_vec();
    {mux_ext_a, mux_en_d, tx_lfsr_taps, tx_lfsr_state, rx_lfsr_taps, rx_lfsr_state} = v4;
    run_len = 16'd5;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (cfg_en) n++;
      if (n == 60) break;
    end
    chk("rst_reach_bit60", L'(n), L'(60));
    rst_n = 1'b0;
    #1;
    chk("arst_cfg_en", L'(cfg_en), L'(0));
    chk("arst_cfg_o", L'(cfg_o), L'(0));
    chk("arst_en", L'(en), L'(0));
    chk("arst_busy", L'(busy), L'(0));
    chk("arst_done", L'(done), L'(0));
    chk("arst_readback", readback, L'(0));
    chk("arst_cycles_run", L'(cycles_run), L'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    v5 = rand_vec();
    do_seq(v5, 16'd3, 0, 1'b0, 1'b0, chain, 3);

    // Saturation with a 4-bit cycle counter
    run_len_s = 4'd0;
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    n = 0;
    begin
      int n_done_s = 0;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        stop_s = 1'b0;
        if (en_s) begin
          n++;
          if (n == 20) stop_s = 1'b1;
        end
        if (done_s) begin
          n_done_s++;
          break;
        end
      end
      chk("sat_done", L'(n_done_s), L'(1));
    end
    chk("sat_en_count", L'(n), L'(20));
    chk("sat_cycles_run", L'(cycles_run_s), L'(15));
    @(negedge clk);
    chk("sat_busy_after", L'(busy_s), L'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
